// File: rtl/clock_ctrl_pkg.sv
// Shared types and BCD helpers for the clock set/alarm controller.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SET_TIME  = 2'd1,
    SET_ALARM = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    HOUR = 2'd0,
    MIN  = 2'd1,
    SEC  = 2'd2
  } field_t;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
  } bcd_time_t;

  localparam int unsigned BCD_W = 8;
  localparam logic [BCD_W-1:0] HOUR_MAX = 8'h23;
  localparam logic [BCD_W-1:0] MS_MAX   = 8'h59;

  // Two-digit BCD increment; anything at/over the limit or with a bad ones digit wraps to 00.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] val,
                                               input logic [BCD_W-1:0] lim);
    logic [BCD_W-1:0] res;
    if (val >= lim || val[3:0] > 4'd9)
      res = 8'h00;
    else if (val[3:0] == 4'd9)
      res = {val[7:4] + 4'd1, 4'd0};
    else
      res = {val[7:4], val[3:0] + 4'd1};
    return res;
  endfunction

endpackage

// File: rtl/key_edge_sync.sv
// Synchronizes one debounced key level and emits a one-cycle pulse on its rising edge.
module key_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign press_c = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Key-driven time/alarm editor for the digital clock, with alarm enable and buzzer timing.
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RING_SEC    = 30,
  parameter logic [15:0] ALARM_RST   = 16'h0700
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_mode,
  input  logic        key_sel,
  input  logic        key_inc,
  input  logic        key_alarm,
  input  logic        tick_1s,
  input  logic [23:0] cur_time,
  input  logic        clock_out,
  output logic [23:0] set_time,
  output logic        set_time_finish,
  output logic [15:0] alarm_time,
  output logic        clock_en,
  output logic        buzzer,
  output logic [1:0]  mode,
  output logic [2:0]  blink_mask
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] RING_LEN = CNT_W'(RING_SEC);

  logic mode_p_c, sel_p_c, inc_p_c, alarm_p_c, co_rise_c, ring_end_c;

  mode_t            state_q, state_d;
  field_t           field_q, field_d;
  bcd_time_t        st_q, st_d;
  logic [15:0]      al_q, al_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fin_q, fin_d, en_q, en_d, cen_q, cen_d;
  logic             buz_q, buz_d, armed_q, armed_d, co_q;
  logic [2:0]       blink_q, blink_d;

  key_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mode  (.clk(clk), .rst(rst), .key(key_mode),  .press_c(mode_p_c));
  key_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sel   (.clk(clk), .rst(rst), .key(key_sel),   .press_c(sel_p_c));
  key_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_inc   (.clk(clk), .rst(rst), .key(key_inc),   .press_c(inc_p_c));
  key_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_alarm (.clk(clk), .rst(rst), .key(key_alarm), .press_c(alarm_p_c));

  assign co_rise_c = clock_out & ~co_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      field_q <= HOUR;
      st_q    <= '0;
      al_q    <= ALARM_RST;
      cnt_q   <= '0;
      fin_q   <= 1'b1;
      en_q    <= 1'b0;
      cen_q   <= 1'b0;
      buz_q   <= 1'b0;
      armed_q <= 1'b1;
      blink_q <= 3'b000;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      st_q    <= st_d;
      al_q    <= al_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
      en_q    <= en_d;
      cen_q   <= cen_d;
      buz_q   <= buz_d;
      armed_q <= armed_d;
      blink_q <= blink_d;
      co_q    <= clock_out;
    end
  end

  always_comb begin
    state_d    = state_q;
    field_d    = field_q;
    st_d       = st_q;
    al_d       = al_q;
    cnt_d      = cnt_q;
    en_d       = en_q;
    buz_d      = buz_q;
    armed_d    = armed_q;
    ring_end_c = 1'b0;
    blink_d    = 3'b000;

    if (buz_q && tick_1s) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == RING_LEN) begin
        buz_d      = 1'b0;
        ring_end_c = 1'b1;
      end
    end

    // A key press during ringing only silences; mode > sel > inc otherwise.
    if (buz_q && (mode_p_c || sel_p_c || inc_p_c)) begin
      buz_d      = 1'b0;
      ring_end_c = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (mode_p_c) begin
            state_d = SET_TIME;
            field_d = HOUR;
            st_d    = bcd_time_t'(cur_time);
          end
        end
        SET_TIME: begin
          if (mode_p_c) begin
            state_d = SET_ALARM;
            field_d = HOUR;
          end else if (sel_p_c) begin
            case (field_q)
              HOUR:    field_d = MIN;
              MIN:     field_d = SEC;
              default: field_d = HOUR;
            endcase
          end else if (inc_p_c) begin
            case (field_q)
              HOUR:    st_d.hh = bcd_inc(st_q.hh, HOUR_MAX);
              MIN:     st_d.mm = bcd_inc(st_q.mm, MS_MAX);
              default: st_d.ss = bcd_inc(st_q.ss, MS_MAX);
            endcase
          end
        end
        default: begin
          if (mode_p_c) begin
            state_d = RUN;
            field_d = HOUR;
          end else if (sel_p_c) begin
            field_d = (field_q == HOUR) ? MIN : HOUR;
          end else if (inc_p_c) begin
            if (field_q == HOUR) al_d[15:8] = bcd_inc(al_q[15:8], HOUR_MAX);
            else                 al_d[7:0]  = bcd_inc(al_q[7:0], MS_MAX);
          end
        end
      endcase
    end

    // Armed blocks retrigger until the live hh:mm leaves the alarm minute.
    if (co_rise_c && en_q && armed_q && !buz_q) begin
      buz_d   = 1'b1;
      cnt_d   = '0;
      armed_d = 1'b0;
    end else if (!armed_q && (cur_time[23:8] != al_q)) begin
      armed_d = 1'b1;
    end

    if (alarm_p_c) begin
      en_d = ~en_q;
      if (en_q) buz_d = 1'b0;
    end

    if (state_d != RUN) begin
      case (field_d)
        HOUR:    blink_d = 3'b100;
        MIN:     blink_d = 3'b010;
        default: blink_d = 3'b001;
      endcase
    end
  end

  assign fin_d = (state_d != SET_TIME);
  assign cen_d = en_d & ~ring_end_c;

  assign set_time        = st_q;
  assign set_time_finish = fin_q;
  assign alarm_time      = al_q;
  assign clock_en        = cen_q;
  assign buzzer          = buz_q;
  assign mode            = state_q;
  assign blink_mask      = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: directed key/ring scenarios with hand-computed expectations.
module tb_clock_set_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_mode, key_sel, key_inc, key_alarm, tick_1s, clock_out;
  logic [23:0] cur_time;
  logic [23:0] set_time;
  logic        set_time_finish, clock_en, buzzer;
  logic [15:0] alarm_time;
  logic [1:0]  mode;
  logic [2:0]  blink_mask;

  clock_set_ctrl #(.SYNC_STAGES(2), .RING_SEC(3), .ALARM_RST(16'h0700)) dut (
    .clk(clk), .rst(rst), .key_mode(key_mode), .key_sel(key_sel), .key_inc(key_inc),
    .key_alarm(key_alarm), .tick_1s(tick_1s), .cur_time(cur_time), .clock_out(clock_out),
    .set_time(set_time), .set_time_finish(set_time_finish), .alarm_time(alarm_time),
    .clock_en(clock_en), .buzzer(buzzer), .mode(mode), .blink_mask(blink_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int unsigned cyc;
    logic [47:0] val;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  logic [23:0] e_st;
  logic        e_fin, e_cen, e_buz;
  logic [15:0] e_al;
  logic [1:0]  e_mode;
  logic [2:0]  e_blink;

  logic [7:0] hrs [0:10] = '{8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19,
                             8'h20, 8'h21, 8'h22, 8'h23};

  localparam int K_MODE = 0, K_SEL = 1, K_INC = 2, K_ALARM = 3;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due at this cycle against the live outputs.
  always @(negedge clk) begin
    exp_t        e;
    logic [47:0] obs;
    obs = {set_time, set_time_finish, alarm_time, clock_en, buzzer, mode, blink_mask};
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      n_tests++;
      if (e.cyc != cyc || obs !== e.val) begin
        n_fail++;
        $display("FAIL %s cyc=%0d {st,fin,al,cen,buz,mode,blink} got=%h required=%h",
                 e.name, cyc, obs, e.val);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name);
    exp_t e;
    e.name = name;
    e.cyc  = cyc;
    e.val  = {e_st, e_fin, e_al, e_cen, e_buz, e_mode, e_blink};
    sb_q.push_back(e);
  endtask

  task automatic press(input int which);
    step(3);
    case (which)
      K_MODE:  key_mode  = 1'b1;
      K_SEL:   key_sel   = 1'b1;
      K_INC:   key_inc   = 1'b1;
      default: key_alarm = 1'b1;
    endcase
    step(3);
    key_mode = 1'b0; key_sel = 1'b0; key_inc = 1'b0; key_alarm = 1'b0;
  endtask

  task automatic tick();
    tick_1s = 1'b1;
    step(1);
    tick_1s = 1'b0;
  endtask

  task automatic ring_start();
    clock_out = 1'b0;
    step(1);
    clock_out = 1'b1;
    step(1);
  endtask

  task automatic exp_reset();
    e_st = 24'h0; e_fin = 1'b1; e_al = 16'h0700; e_cen = 1'b0;
    e_buz = 1'b0; e_mode = 2'd0; e_blink = 3'b000;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; key_mode = 1'b0; key_sel = 1'b0; key_inc = 1'b0; key_alarm = 1'b0;
    tick_1s = 1'b0; clock_out = 1'b0; cur_time = 24'h125959;
    exp_reset();
    step(3);
    chk("rst_hold");
    rst = 1'b0;
    step(1);
    chk("reset_values");

    // Enter SET_TIME, live time captured
    press(K_MODE);
    e_mode = 2'd1; e_st = 24'h125959; e_blink = 3'b100; e_fin = 1'b0;
    chk("enter_set_time");

    // Hour 12 -> 23 (crossing 19->20), then wrap to 00
    for (int i = 0; i < 11; i++) begin
      press(K_INC);
      e_st[23:16] = hrs[i];
      chk("inc_hour");
    end
    press(K_INC);  e_st[23:16] = 8'h00; chk("hour_wrap");
    press(K_SEL);  e_blink = 3'b010;    chk("sel_min");
    press(K_SEL);  e_blink = 3'b001;    chk("sel_sec");
    press(K_INC);  e_st[7:0] = 8'h00;   chk("sec_wrap_no_carry");
    press(K_SEL);  e_blink = 3'b100;    chk("sel_back_hour");

    // SET_ALARM: HOUR/MIN only, minute 00..59 then wrap
    press(K_MODE); e_mode = 2'd2; e_fin = 1'b1; e_blink = 3'b100; chk("enter_set_alarm");
    press(K_SEL);  e_blink = 3'b010; chk("alarm_sel_min");
    press(K_SEL);  e_blink = 3'b100; chk("alarm_sel_wrap_hour");
    press(K_SEL);  e_blink = 3'b010; chk("alarm_sel_min2");
    for (int i = 0; i < 10; i++) press(K_INC);
    e_al = 16'h0710; chk("alarm_min_10");
    for (int i = 0; i < 49; i++) press(K_INC);
    e_al = 16'h0759; chk("alarm_min_59");
    press(K_INC);  e_al = 16'h0700; chk("alarm_min_wrap");
    press(K_MODE); e_mode = 2'd0; e_blink = 3'b000; chk("back_to_run");

    // Ring timing and clear pulse
    press(K_ALARM); e_cen = 1'b1; chk("alarm_enable");
    cur_time = 24'h070000;
    ring_start();   e_buz = 1'b1; chk("ring_start");
    tick(); tick(); chk("ring_two_ticks");
    tick();         e_buz = 1'b0; e_cen = 1'b0; chk("ring_timeout");
    step(1);        e_cen = 1'b1; chk("clear_pulse_one_cycle");
    clock_out = 1'b0;
    step(2);
    clock_out = 1'b1;
    step(3);        chk("no_retrigger_same_minute");
    cur_time = 24'h070100;
    step(1);
    press(K_MODE);
    e_mode = 2'd1; e_st = 24'h070100; e_blink = 3'b100; e_fin = 1'b0;
    chk("enter_set_time_2");

    // Ringing while editing: inc only silences
    cur_time = 24'h070000;
    ring_start();   e_buz = 1'b1; chk("ring_in_set_time");
    press(K_INC);   e_buz = 1'b0; e_cen = 1'b0; chk("inc_silences_only");
    step(1);        e_cen = 1'b1; chk("silence_clear_pulse");
    cur_time = 24'h070100;
    step(1);
    cur_time = 24'h070000;
    ring_start();   e_buz = 1'b1; chk("ring_again");
    press(K_ALARM); e_buz = 1'b0; e_cen = 1'b0; chk("alarm_off_silences");

    // Priority, held key, async reset
    press(K_MODE);  e_mode = 2'd2; e_fin = 1'b1; e_blink = 3'b100; chk("to_set_alarm");
    press(K_MODE);  e_mode = 2'd0; e_blink = 3'b000; chk("to_run");
    step(3);
    key_mode = 1'b1; key_sel = 1'b1; key_inc = 1'b1;
    step(3);
    key_mode = 1'b0; key_sel = 1'b0; key_inc = 1'b0;
    e_mode = 2'd1; e_st = 24'h070000; e_blink = 3'b100; e_fin = 1'b0;
    chk("simultaneous_mode_wins");
    step(3);
    key_inc = 1'b1;
    step(100);
    key_inc = 1'b0;
    e_st = 24'h080000;
    chk("held_key_one_inc");
    step(2);
    rst = 1'b1;
    step(1);
    exp_reset();
    chk("async_reset_mid_edit");
    rst = 1'b0;
    step(2);
    chk("after_reset_release");

    step(2);
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain pending=%0d required=0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
